// File: rtl/dmem_pkg.sv
// dmem_pkg: shared owner encoding, in-flight tag and counter width for the data memory arbiter.
package dmem_pkg;
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;
  localparam int STARVE_CNT_W = 4;
  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_tag_t;
endpackage

// File: rtl/dmem_rsp_tracker.sv
// dmem_rsp_tracker: two-stage read owner pipeline steering returned memory data to the owning port.
module dmem_rsp_tracker
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  rsp_tag_t              tag_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o
);
  rsp_tag_t s1_q, s2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= tag_i;
      s2_q <= s1_q;
    end
  end
  assign m0_rvalid_o = s2_q.valid & (s2_q.owner == OWNER_M0);
  assign m1_rvalid_o = s2_q.valid & (s2_q.owner == OWNER_M1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter for the data memory with starvation protection for port 1.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  arb_stall
);
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic read_q, write_q, force_m1, any_gnt, sel_we;
  // Force mode hands the slot to port 1 even when the pipeline is asking.
  assign force_m1  = starve_q == STARVE_CNT_W'(STARVE_LIMIT);
  assign m0_gnt    = m0_req & ~force_m1;
  assign m1_gnt    = m1_req & (force_m1 | ~m0_req);
  assign arb_stall = m0_req & ~m0_gnt;
  assign any_gnt   = m0_gnt | m1_gnt;
  assign sel_we    = m1_gnt ? m1_we : m0_we;
  always_comb starve_d = (!m1_req || m1_gnt) ? '0 : force_m1 ? starve_q : starve_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      read_q   <= any_gnt & ~sel_we;
      write_q  <= any_gnt & sel_we;
      if (any_gnt) begin
        addr_q  <= m1_gnt ? m1_addr : m0_addr;
        wdata_q <= m1_gnt ? m1_wdata : m0_wdata;
      end
    end
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = read_q;
  assign mem_write = write_q;
  dmem_rsp_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
    .clk         (clk),
    .reset_n     (reset_n),
    .tag_i       ('{valid: any_gnt & ~sel_we, owner: m1_gnt ? OWNER_M1 : OWNER_M0}),
    .mem_rdata_i (mem_rdata),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write, arb_stall;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .arb_stall(arb_stall)
  );

  function automatic logic [31:0] dflt(input logic [3:0] i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Bench memory: 16 words; unwritten words read a fixed pattern, idle cycles drive junk.
  logic [31:0] tb_mem [16];
  logic [15:0] tb_wr = '0;
  always @(posedge clk) begin
    if (mem_write) begin
      tb_mem[mem_addr[5:2]] <= mem_wdata;
      tb_wr[mem_addr[5:2]]  <= 1'b1;
    end
    mem_rdata <= mem_read ? (tb_wr[mem_addr[5:2]] ? tb_mem[mem_addr[5:2]] : dflt(mem_addr[5:2])) : $urandom;
  end

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } rd_t;
  rd_t pend[$];
  int vectors = 0, miscompares = 0, cyc = 0, starve = 0;
  logic exp_rd = 0, exp_wr = 0, g0 = 0, g1 = 0, obs_g1 = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [31:0] mm [16];
  logic [15:0] mw = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    starve = 0;
    exp_rd = 0;
    exp_wr = 0;
    exp_addr = 0;
    exp_wdata = 0;
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  // One cycle: called at a negedge with inputs set; checks mid-cycle, advances the model, returns at next negedge.
  task automatic step();
    logic v0, v1, we;
    logic [31:0] d;
    logic [3:0] i;
    #1;
    g0 = m0_req && starve != LIMIT;
    g1 = m1_req && (starve == LIMIT || !m0_req);
    obs_g1 = m1_gnt;
    v0 = pend.size() > 0 && pend[0].due == cyc && pend[0].owner == 1'b0;
    v1 = pend.size() > 0 && pend[0].due == cyc && pend[0].owner == 1'b1;
    d = (v0 || v1) ? pend[0].data : 32'h0;
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("arb_stall", 32'(arb_stall), 32'(m0_req && !g0));
    chk("mem_read", 32'(mem_read), 32'(exp_rd));
    chk("mem_write", 32'(mem_write), 32'(exp_wr));
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(v0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(v1));
    chk("m0_rdata", m0_rdata, v0 ? d : 32'h0);
    chk("m1_rdata", m1_rdata, v1 ? d : 32'h0);
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (g0 || g1) begin
      we = g1 ? m1_we : m0_we;
      exp_addr = g1 ? m1_addr : m0_addr;
      exp_wdata = g1 ? m1_wdata : m0_wdata;
      exp_rd = !we;
      exp_wr = we;
      i = exp_addr[5:2];
      if (we) begin
        mm[i] = exp_wdata;
        mw[i] = 1'b1;
      end else pend.push_back('{g1, mw[i] ? mm[i] : dflt(i), cyc + 2});
    end else begin
      exp_rd = 0;
      exp_wr = 0;
    end
    starve = (m1_req && !g1) ? (starve < LIMIT ? starve + 1 : LIMIT) : 0;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();
    // Port 0: store DEADBEEF at 0x10 then read it back.
    set0(1, 1, 32'h10, 32'hDEAD_BEEF); step();
    set0(1, 0, 32'h10, 32'h0); step();
    set0(0, 0, 32'h0, 32'h0); repeat (3) step();
    // Port 1 write with port 0 idle.
    set1(1, 1, 32'h40, 32'h1234); step();
    set1(0, 0, 32'h0, 32'h0); repeat (3) step();
    // Continuous contention: port 1 wins every fifth cycle.
    set0(1, 0, 32'h8, 32'h0);
    set1(1, 0, 32'hC, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("starve_pattern", 32'(obs_g1), 32'(k % 5 == 4));
    end
    set0(0, 0, 32'h0, 32'h0);
    set1(0, 0, 32'h0, 32'h0);
    // Interleaved reads of 0xA / 0xB to different owners.
    set0(1, 1, 32'h0, 32'hA); step();
    set0(1, 1, 32'h4, 32'hB); step();
    set0(0, 0, 32'h0, 32'h0); step();
    set0(1, 0, 32'h0, 32'h0); step();
    set0(0, 0, 32'h0, 32'h0); set1(1, 0, 32'h4, 32'h0); step();
    set1(0, 0, 32'h0, 32'h0); repeat (3) step();
    repeat (10) step();
    // Reset while a read is in flight.
    set0(1, 0, 32'h10, 32'h0); step();
    set0(0, 0, 32'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mid_m0_rvalid", 32'(m0_rvalid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (5) step();
    // Random traffic honouring the hold-until-grant contract, with occasional cancels.
    for (int k = 0; k < 400; k++) begin
      if (!m0_req || g0) set0($urandom % 4 != 0, 1'($urandom), $urandom, $urandom);
      else if ($urandom % 16 == 0) m0_req = 0;
      if (!m1_req || g1) set1($urandom % 3 != 0, 1'($urandom), $urandom, $urandom);
      else if ($urandom % 16 == 0) m1_req = 0;
      step();
    end
    set0(0, 0, 32'h0, 32'h0);
    set1(0, 0, 32'h0, 32'h0);
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - Port 0: the pipeline MEM stage. High priority.
  - Port 1: a secondary master such as DMA or the debug loader. Low priority, protected from starvation.
- Grants one access per cycle, registers the memory command, and routes returned read data to the owning port.
- Raises a stall to the hazard unit whenever the pipeline request is not granted.

Parameters:
- ADDR_WIDTH, 32, address width of both ports and of the memory.
- DATA_WIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive denied cycles of port 1 before port 1 is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- m0_req  in  1  pipeline access request.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  byte address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_gnt  out  1  combinational grant, same cycle as request.
- m0_rvalid  out  1  read data valid pulse.
- m0_rdata  out  DATA_WIDTH  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 set, for port 1.
- mem_addr  out  ADDR_WIDTH  registered command address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_read  out  1  registered read strobe.
- mem_write  out  1  registered write strobe.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_read.
- arb_stall  out  1  m0_req & ~m0_gnt, to hazard unit.

Behaviour:
- Reset (async, reset_n low): all registered outputs 0.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - m0_rvalid = 0, m1_rvalid = 0; m0_rdata and m1_rdata read 0.
  - Starvation counter = 0; in-flight tracking cleared.
- Reset mid-operation: outstanding reads are discarded and no rvalid is produced after release.
- Grant (combinational, at most one per cycle):
  - Default: m0_gnt = m0_req; m1_gnt = m1_req & ~m0_req.
  - Force mode is active when starve_cnt == STARVE_LIMIT. In force mode: m1_gnt = m1_req and m0_gnt = 0.
  - m0_gnt and m1_gnt are never both 1.
- Starvation counter (width 4):
  - Increments when m1_req & ~m1_gnt.
  - Clears to 0 on m1_gnt or when m1_req = 0.
  - Saturates at STARVE_LIMIT.
- Pipeline of a granted access. Call the grant cycle T.
  - T+1: mem_addr, mem_wdata and mem_read/mem_write are driven from the granted port's signals, captured on the edge ending cycle T.
  - Cycles with no grant drive mem_read = mem_write = 0. mem_addr and mem_wdata hold their last value.
  - Read in-flight tracking: a 2-stage shift of {valid, owner}. Stage 1 is loaded at the end of T; stage 2 at the end of T+1.
  - T+2: mN_rvalid = 1 for the owner, where mN_rvalid is the stage-2 valid for that owner.
  - mN_rdata = mem_rdata while mN_rvalid is 1, else 0.
  - Writes produce no rvalid. A write completes at T+1.
- Throughput: back-to-back grants every cycle, mixed owners allowed. Read data returns in grant order, one per cycle.
- Requester contract: a port holds req, we, addr and wdata stable until it sees gnt. Dropping req before gnt is legal and cancels the request; no side effects.
- arb_stall is combinational and equals m0_req & ~m0_gnt.
- Boundary conditions:
  - STARVE_LIMIT = 1: port 1 wins every second contested cycle.
  - Both requests idle: no memory strobes.
  - m0_req toggling does not reset the counter; only m1 events affect it.

Decomposition:
- Shared package dmem_pkg holds:
  - localparam OWNER_M0 = 1'b0, OWNER_M1 = 1'b1.
  - The in-flight tag struct {valid, owner}.
  - The STARVE_CNT_W = 4 constant.
- One natural sub-module, dmem_rsp_tracker: the 2-stage owner shift register plus rvalid/rdata steering.
- Grant logic and the command register stay in the top level.

Test Plan:
- Port 0 read only: m0_req = 1, we = 0, addr = 0x10, memory returns 0xDEADBEEF.
  - Required: m0_gnt high at T; mem_read = 1 with mem_addr = 0x10 at T+1; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF at T+2; arb_stall = 0 throughout.
- Port 1 write, m0 idle: m1_req = 1, we = 1, addr = 0x40, wdata = 0x1234.
  - Required: m1_gnt at T; mem_write = 1, mem_addr = 0x40, mem_wdata = 0x1234 at T+1; no rvalid on either port.
- Starvation, STARVE_LIMIT = 4: m0_req and m1_req held high continuously (reads).
  - Required: m0 granted for 4 cycles; 5th cycle m1_gnt = 1, m0_gnt = 0, arb_stall = 1; counter clears; pattern repeats every 5 cycles.
- Interleaved reads: m0 read 0x0 at T, m1 read 0x4 at T+1, memory returns 0xA then 0xB.
  - Required: m0_rvalid with 0xA at T+2; m1_rvalid with 0xB at T+3; no cross-delivery.
- Reset mid-flight: grant a read at T, pull reset_n low during T+1, release at T+3.
  - Required: mem_read = 0 immediately on reset assertion; no rvalid at any time after release; counter = 0.
- Idle: both req = 0 for 10 cycles.
  - Required: mem_read = mem_write = 0, gnt = 0 on both ports, rvalid = 0 on both ports, arb_stall = 0.
